// File: rtl/iob_eth_dma_sched.sv
// Round-robin scheduler serialising RX/TX transfer requests onto the Ethernet DMA run interface.
// Latency: dma_run one cycle after a request is taken in IDLE; ack in DONE once the DMA returns idle.
// Backpressure: requests are level-held until ack; one transfer in flight; en gates only new grants.
module iob_eth_dma_sched #(
    parameter int AXI_ADDR_W   = 32,
    parameter int CNT_W        = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  rx_req,
    input  logic [AXI_ADDR_W-1:0] rx_addr,
    input  logic [10:0]           rx_start_index,
    output logic                  rx_ack,
    output logic [CNT_W-1:0]      rx_done_cnt,
    input  logic                  tx_req,
    input  logic [AXI_ADDR_W-1:0] tx_addr,
    input  logic [10:0]           tx_start_index,
    output logic                  tx_ack,
    output logic [CNT_W-1:0]      tx_done_cnt,
    output logic [AXI_ADDR_W-1:0] dma_addr,
    output logic [10:0]           dma_start_index,
    output logic                  dma_read_from_not_write,
    output logic                  dma_run,
    input  logic                  dma_ready,
    output logic                  busy,
    output logic                  timeout_flag,
    input  logic                  clr_flag
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [10:0]           start_index;
        logic                  dir;
    } cfg_t;

    state_t     state, state_nxt;
    cfg_t       cfg;
    logic       last_grant_rx;
    logic [7:0] wait_cnt;
    logic       grant;
    logic       pick_rx;
    logic       tmo_hit;

    // On contention the channel that did not win last time is chosen.
    assign pick_rx = rx_req & (~tx_req | ~last_grant_rx);

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (en && (rx_req || tx_req)) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!dma_ready) begin
                    state_nxt = WAIT_DONE;
                end else if (wait_cnt == 8'(BUSY_TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            WAIT_DONE: begin
                if (dma_ready) state_nxt = DONE;
            end
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg           <= '0;
            last_grant_rx <= 1'b0;
            wait_cnt      <= 8'd0;
            timeout_flag  <= 1'b0;
            rx_done_cnt   <= '0;
            tx_done_cnt   <= '0;
        end else begin
            if (grant) begin
                if (pick_rx) begin
                    cfg.addr        <= rx_addr;
                    cfg.start_index <= rx_start_index;
                    cfg.dir         <= 1'b1;
                end else begin
                    cfg.addr        <= tx_addr;
                    cfg.start_index <= tx_start_index;
                    cfg.dir         <= 1'b0;
                end
            end
            if (state == ISSUE) begin
                wait_cnt <= 8'd0;
            end else if (state == WAIT_BUSY && dma_ready && !tmo_hit) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            // A timeout in the same cycle as a clear leaves the flag set.
            if (tmo_hit)       timeout_flag <= 1'b1;
            else if (clr_flag) timeout_flag <= 1'b0;
            if (state == DONE) begin
                last_grant_rx <= cfg.dir;
                if (cfg.dir) rx_done_cnt <= rx_done_cnt + CNT_W'(1);
                else         tx_done_cnt <= tx_done_cnt + CNT_W'(1);
            end
        end
    end

    assign dma_addr                = cfg.addr;
    assign dma_start_index         = cfg.start_index;
    assign dma_read_from_not_write = cfg.dir;
    assign dma_run                 = (state == ISSUE);
    assign busy                    = (state != IDLE);
    assign rx_ack                  = (state == DONE) &  cfg.dir;
    assign tx_ack                  = (state == DONE) & ~cfg.dir;

endmodule
